// File: rtl/axil_axis_pkg.sv
// Shared register map, ap_ctrl bit positions, read-FSM encodings and defaults
// for the AXI-Lite controlled stream responder.
package axil_axis_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_OFFSET   = 32'h14;

  localparam int AP_START_BIT  = 0;
  localparam int AP_DONE_BIT   = 1;
  localparam int AP_IDLE_BIT   = 2;
  localparam int TLAST_ERR_BIT = 3;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  typedef struct packed {
    logic tlast_err;
    logic ap_idle;
    logic ap_done;
    logic ap_start;
  } ap_ctrl_t;

  localparam ap_ctrl_t AP_CTRL_RESET = '{tlast_err: 1'b0, ap_idle: 1'b1,
                                         ap_done: 1'b0, ap_start: 1'b0};

  function automatic logic [31:0] ap_ctrl_word(input ap_ctrl_t c);
    logic [31:0] w;
    w                = '0;
    w[AP_START_BIT]  = c.ap_start;
    w[AP_DONE_BIT]   = c.ap_done;
    w[AP_IDLE_BIT]   = c.ap_idle;
    w[TLAST_ERR_BIT] = c.tlast_err;
    return w;
  endfunction

endpackage

// File: rtl/axil_axis_responder_if.sv
// Bundles the AXI-Lite slave port and both AXI-Stream ports of the responder.
interface axil_axis_responder_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);

  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid, ss_tready, ss_tlast;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   sm_tvalid, sm_tready, sm_tlast;
  logic [pDATA_WIDTH-1:0] sm_tdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags derived from an occupancy counter;
// push and pop may happen in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axil_axis_responder.sv
// AXI-Lite controlled responder: accepts data_length stream beats, buffers them
// and re-emits each one with the programmed offset added.
module axil_axis_responder
  import axil_axis_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  axil_axis_responder_if.slave bus
);

  logic                   wr_ready_q, wr_ready_d;
  logic [1:0]             rd_state_q, rd_state_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rd_clr_done_q, rd_clr_done_d;
  ap_ctrl_t               ap_ctrl_q, ap_ctrl_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic [pDATA_WIDTH-1:0] offset_q, offset_d;
  logic [pDATA_WIDTH-1:0] in_count_q, in_count_d;
  logic [pDATA_WIDTH-1:0] out_count_q, out_count_d;

  logic                   wr_fire, rd_fire, push, pop;
  logic                   ss_tready, sm_tvalid, sm_tlast, fifo_full, fifo_empty;
  logic [pDATA_WIDTH-1:0] fifo_dout, last_index, rd_mux;

  assign wr_ready_d = bus.awvalid && bus.wvalid && !wr_ready_q;
  assign wr_fire    = bus.awvalid && bus.wvalid && wr_ready_q;
  assign rd_fire    = (rd_state_q == R_DATA) && bus.rready;
  assign last_index = data_length_q - pDATA_WIDTH'(1);
  assign ss_tready  = !ap_ctrl_q.ap_idle && (in_count_q < data_length_q) && !fifo_full;
  assign push       = bus.ss_tvalid && ss_tready;
  assign sm_tvalid  = !fifo_empty;
  assign sm_tlast   = sm_tvalid && (out_count_q == last_index);
  assign pop        = sm_tvalid && bus.sm_tready;

  assign bus.awready   = wr_ready_q;
  assign bus.wready    = wr_ready_q;
  assign bus.arready   = (rd_state_q == R_ADDR);
  assign bus.rvalid    = (rd_state_q == R_DATA);
  assign bus.rdata     = rdata_q;
  assign bus.ss_tready = ss_tready;
  assign bus.sm_tvalid = sm_tvalid;
  assign bus.sm_tdata  = fifo_dout + offset_q;
  assign bus.sm_tlast  = sm_tlast;

  sync_fifo #(
    .WIDTH (pDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .din   (bus.ss_tdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rd_mux = '0;
    if (bus.araddr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
      rd_mux = pDATA_WIDTH'(ap_ctrl_word(ap_ctrl_q));
    end else if (bus.araddr == pADDR_WIDTH'(ADDR_DATA_LEN)) begin
      rd_mux = data_length_q;
    end else if (bus.araddr == pADDR_WIDTH'(ADDR_OFFSET)) begin
      rd_mux = offset_q;
    end
  end

  // ap_done is cleared only if the returned word actually showed it set.
  always_comb begin
    rd_state_d    = rd_state_q;
    rdata_d       = rdata_q;
    rd_clr_done_d = rd_clr_done_q;
    case (rd_state_q)
      R_IDLE: if (bus.arvalid) rd_state_d = R_ADDR;
      R_ADDR: begin
        if (bus.arvalid) begin
          rd_state_d    = R_DATA;
          rdata_d       = rd_mux;
          rd_clr_done_d = (bus.araddr == pADDR_WIDTH'(ADDR_AP_CTRL)) && ap_ctrl_q.ap_done;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: if (bus.rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ap_ctrl_d          = ap_ctrl_q;
    ap_ctrl_d.ap_start = 1'b0;
    data_length_d      = data_length_q;
    offset_d           = offset_q;
    in_count_d         = in_count_q;
    out_count_d        = out_count_q;
    if (rd_fire && rd_clr_done_q) ap_ctrl_d.ap_done = 1'b0;
    if (ap_ctrl_q.ap_start && (data_length_q == '0)) begin
      ap_ctrl_d.ap_done = 1'b1;
      ap_ctrl_d.ap_idle = 1'b1;
    end
    if (wr_fire && ap_ctrl_q.ap_idle) begin
      if (bus.awaddr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
        if (bus.wdata[AP_START_BIT]) begin
          ap_ctrl_d   = '{tlast_err: 1'b0, ap_idle: 1'b0, ap_done: 1'b0, ap_start: 1'b1};
          in_count_d  = '0;
          out_count_d = '0;
        end
      end else if (bus.awaddr == pADDR_WIDTH'(ADDR_DATA_LEN)) begin
        data_length_d = bus.wdata;
      end else if (bus.awaddr == pADDR_WIDTH'(ADDR_OFFSET)) begin
        offset_d = bus.wdata;
      end
    end
    if (push) begin
      in_count_d = in_count_q + pDATA_WIDTH'(1);
      if (bus.ss_tlast != (in_count_q == last_index)) ap_ctrl_d.tlast_err = 1'b1;
    end
    if (pop) begin
      out_count_d = out_count_q + pDATA_WIDTH'(1);
      if (sm_tlast) begin
        ap_ctrl_d.ap_done = 1'b1;
        ap_ctrl_d.ap_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ready_q    <= 1'b0;
      rd_state_q    <= R_IDLE;
      rdata_q       <= '0;
      rd_clr_done_q <= 1'b0;
      ap_ctrl_q     <= AP_CTRL_RESET;
      data_length_q <= '0;
      offset_q      <= '0;
      in_count_q    <= '0;
      out_count_q   <= '0;
    end else begin
      wr_ready_q    <= wr_ready_d;
      rd_state_q    <= rd_state_d;
      rdata_q       <= rdata_d;
      rd_clr_done_q <= rd_clr_done_d;
      ap_ctrl_q     <= ap_ctrl_d;
      data_length_q <= data_length_d;
      offset_q      <= offset_d;
      in_count_q    <= in_count_d;
      out_count_q   <= out_count_d;
    end
  end

endmodule
